// File: rtl/cpu64_l1_evict_reader_pkg.sv
// Shared constants and types for the L1 eviction / probe-response reader:
// line geometry, MESI encodings, TileLink C-channel opcodes and FSM states.
package cpu64_l1_evict_reader_pkg;

  // Line geometry: a 64-byte line is moved as eight 64-bit words.
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned BEATS      = LINE_BYTES / WORD_BYTES;
  localparam int unsigned OFFSET_W   = 6;
  localparam int unsigned WORD_W     = 3;

  // TileLink size field for a full line (log2 of LINE_BYTES).
  localparam logic [3:0] C_SIZE_LINE = 4'd6;

  // Coherence state of a line as held in the state array.
  typedef enum logic [1:0] {
    MESI_N  = 2'd0,  // nothing (invalid)
    MESI_B  = 2'd1,  // branch (shared, clean)
    MESI_T  = 2'd2,  // trunk (exclusive, clean)
    MESI_TT = 2'd3   // dirty trunk: line must be written back with data
  } mesi_e;

  // TileLink C-channel opcodes used by this block.
  localparam logic [2:0] TL_C_PROBEACK     = 3'd4;
  localparam logic [2:0] TL_C_PROBEACKDATA = 3'd5;
  localparam logic [2:0] TL_C_RELEASE      = 3'd6;
  localparam logic [2:0] TL_C_RELEASEDATA  = 3'd7;

  // Reader FSM.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2,
    ST_UPDATE = 2'd3
  } evict_state_e;

  // Select the C-channel opcode from message family and whether data rides along.
  function automatic logic [2:0] c_opcode(input logic is_release, input logic has_data);
    logic [2:0] op;
    if (is_release) op = has_data ? TL_C_RELEASEDATA : TL_C_RELEASE;
    else            op = has_data ? TL_C_PROBEACKDATA : TL_C_PROBEACK;
    return op;
  endfunction

endpackage

// File: rtl/cpu64_l1_evict_reader.sv
// L1 eviction / probe-response reader. Reads a victim or probed line out of
// the data/tag/state arrays one word per beat, emits it on the TileLink C
// channel, then rewrites the line's tag with its new coherence state.
// While busy_o is high this block owns the array port; the L1 top muxes the
// port between this block and the fill path on busy_o.
module cpu64_l1_evict_reader
  import cpu64_l1_evict_reader_pkg::*;
#(
  parameter int SETS     = 32,
  parameter int WAYS     = 8,
  parameter int TAG_W    = 53,
  parameter int INDEX_W  = 5,
  parameter int SOURCE_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,

  // Request from the miss/probe controller
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_is_release_i,
  input  logic [INDEX_W-1:0]  req_index_i,
  input  logic [2:0]          req_way_i,
  input  logic [2:0]          req_param_i,
  input  logic [1:0]          req_new_state_i,
  input  logic [SOURCE_W-1:0] req_source_i,
  output logic                busy_o,
  output logic                done_o,

  // Array read/write port
  output logic [INDEX_W-1:0]  arr_index_o,
  output logic [2:0]          arr_word_sel_o,
  output logic [2:0]          arr_way_sel_o,
  input  logic [63:0]         arr_rdata_i,
  input  logic [TAG_W-1:0]    arr_tag_i,
  input  logic [1:0]          arr_state_i,
  output logic                arr_write_en_o,
  output logic [7:0]          arr_be_o,
  output logic [TAG_W-1:0]    arr_tag_o,
  output logic [1:0]          arr_state_o,

  // TileLink C channel
  output logic                c_valid_o,
  input  logic                c_ready_i,
  output logic [2:0]          c_opcode_o,
  output logic [2:0]          c_param_o,
  output logic [3:0]          c_size_o,
  output logic [SOURCE_W-1:0] c_source_o,
  output logic [63:0]         c_address_o,
  output logic [63:0]         c_data_o
);

  // Geometry sanity: the way/word selects are fixed at 3 bits and the
  // address is {tag, index, offset} packed into 64 bits.
  if (WAYS != 8 || SETS != (1 << INDEX_W) || (TAG_W + INDEX_W + OFFSET_W) != 64)
  begin : g_bad_geometry
    $error("cpu64_l1_evict_reader: unsupported cache geometry");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  evict_state_e          state_q;
  logic [INDEX_W-1:0]    index_q;
  logic [2:0]            way_q;
  logic                  is_release_q;
  logic [2:0]            param_q;
  logic [1:0]            new_state_q;
  logic [SOURCE_W-1:0]   source_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  dirty_q;
  logic [63:0]           c_data_q;
  logic [WORD_W-1:0]     rd_ptr_q;
  logic [WORD_W-1:0]     beat_cnt_q;

  logic in_lookup;
  logic in_send;
  logic in_update;
  logic c_fire;
  logic last_beat;

  assign in_lookup = (state_q == ST_LOOKUP);
  assign in_send   = (state_q == ST_SEND);
  assign in_update = (state_q == ST_UPDATE);
  assign c_fire    = in_send && c_ready_i;

  // A clean line is a single dataless beat; a dirty line ends on its eighth beat.
  assign last_beat = !dirty_q || (beat_cnt_q == WORD_W'(BEATS - 1));

  // -------------------------------------------------------------------------
  // FSM and datapath registers
  // -------------------------------------------------------------------------
  // Sequence request capture, array lookup, beat transmission and state update.
  // NOTE: every register here uses non-blocking assignment so that all
  // next-state values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      way_q        <= '0;
      is_release_q <= 1'b0;
      param_q      <= '0;
      new_state_q  <= '0;
      source_q     <= '0;
      tag_q        <= '0;
      dirty_q      <= 1'b0;
      c_data_q     <= '0;
      rd_ptr_q     <= '0;
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            index_q      <= req_index_i;
            way_q        <= req_way_i;
            is_release_q <= req_is_release_i;
            param_q      <= req_param_i;
            new_state_q  <= req_new_state_i;
            source_q     <= req_source_i;
            state_q      <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          // Word 0 is on arr_rdata_i now; preload it so the first beat is
          // presented straight out of a register with no bubble.
          tag_q      <= arr_tag_i;
          dirty_q    <= (arr_state_i == MESI_TT);
          c_data_q   <= arr_rdata_i;
          rd_ptr_q   <= WORD_W'(1);
          beat_cnt_q <= '0;
          state_q    <= ST_SEND;
        end

        ST_SEND: begin
          if (c_fire) begin
            if (last_beat) begin
              state_q <= ST_UPDATE;
            end else begin
              // arr_word_sel_o is rd_ptr_q, so this loads the next word.
              // rd_ptr_q wraps to 0 after word 7; that read is never sent.
              c_data_q   <= arr_rdata_i;
              rd_ptr_q   <= rd_ptr_q + WORD_W'(1);
              beat_cnt_q <= beat_cnt_q + WORD_W'(1);
            end
          end
        end

        ST_UPDATE: begin
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only, so no input-to-output paths.
  // -------------------------------------------------------------------------
  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = in_update;

  // Array port: addressed only while this block owns it.
  assign arr_index_o    = busy_o ? index_q : '0;
  assign arr_way_sel_o  = busy_o ? way_q : '0;
  assign arr_word_sel_o = in_send ? rd_ptr_q : '0;

  // State-only write: the tag goes back unchanged and no data bytes are enabled.
  assign arr_write_en_o = in_update;
  assign arr_be_o       = '0;
  assign arr_tag_o      = in_update ? tag_q : '0;
  assign arr_state_o    = in_update ? new_state_q : '0;

  // C channel: every field comes from a register, so all of them hold steady
  // while a beat is stalled by c_ready_i.
  assign c_valid_o   = in_send;
  assign c_opcode_o  = in_send ? c_opcode(is_release_q, dirty_q) : '0;
  assign c_param_o   = in_send ? param_q : '0;
  assign c_size_o    = C_SIZE_LINE;
  assign c_source_o  = in_send ? source_q : '0;
  assign c_address_o = in_send ? {tag_q, index_q, {OFFSET_W{1'b0}}} : '0;
  assign c_data_o    = (in_send && dirty_q) ? c_data_q : '0;

  // in_lookup documents the capture cycle; it has no output of its own.
  logic unused_lookup;
  assign unused_lookup = in_lookup;

endmodule

// File: tb/tb_cpu64_l1_evict_reader.sv
// Self-checking bench for cpu64_l1_evict_reader. Models the L1 arrays as
// plain arrays and predicts each C-channel message from the line's state:
// dirty lines go out as eight data beats in word order, everything else as
// one dataless beat, followed by a one-cycle state update.
module tb_cpu64_l1_evict_reader;
  import cpu64_l1_evict_reader_pkg::*;

  localparam int TAG_W = 53;
  localparam int INDEX_W = 5;
  localparam int SOURCE_W = 4;
  localparam int BUDGET = 80;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic                req_valid_i, req_ready_o, req_is_release_i;
  logic [INDEX_W-1:0]  req_index_i;
  logic [2:0]          req_way_i, req_param_i;
  logic [1:0]          req_new_state_i;
  logic [SOURCE_W-1:0] req_source_i;
  logic                busy_o, done_o;
  logic [INDEX_W-1:0]  arr_index_o;
  logic [2:0]          arr_word_sel_o, arr_way_sel_o;
  logic [63:0]         arr_rdata_i;
  logic [TAG_W-1:0]    arr_tag_i, arr_tag_o;
  logic [1:0]          arr_state_i, arr_state_o;
  logic                arr_write_en_o;
  logic [7:0]          arr_be_o;
  logic                c_valid_o, c_ready_i;
  logic [2:0]          c_opcode_o, c_param_o;
  logic [3:0]          c_size_o;
  logic [SOURCE_W-1:0] c_source_o;
  logic [63:0]         c_address_o, c_data_o;

  cpu64_l1_evict_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_release_i(req_is_release_i), .req_index_i(req_index_i),
    .req_way_i(req_way_i), .req_param_i(req_param_i),
    .req_new_state_i(req_new_state_i), .req_source_i(req_source_i),
    .busy_o(busy_o), .done_o(done_o),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o),
    .arr_way_sel_o(arr_way_sel_o), .arr_rdata_i(arr_rdata_i),
    .arr_tag_i(arr_tag_i), .arr_state_i(arr_state_i),
    .arr_write_en_o(arr_write_en_o), .arr_be_o(arr_be_o),
    .arr_tag_o(arr_tag_o), .arr_state_o(arr_state_o),
    .c_valid_o(c_valid_o), .c_ready_i(c_ready_i),
    .c_opcode_o(c_opcode_o), .c_param_o(c_param_o), .c_size_o(c_size_o),
    .c_source_o(c_source_o), .c_address_o(c_address_o), .c_data_o(c_data_o)
  );

  // Array model: combinational reads, contents owned by the stimulus block.
  logic [63:0]      mem  [32][8][8];
  logic [TAG_W-1:0] tags [32][8];
  logic [1:0]       sts  [32][8];

  assign arr_rdata_i = mem[arr_index_o][arr_way_sel_o][arr_word_sel_o];
  assign arr_tag_i   = tags[arr_index_o][arr_way_sel_o];
  assign arr_state_i = sts[arr_index_o][arr_way_sel_o];

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;

  // Count every array write strobe the DUT issues.
  always @(posedge clk_i) if (arr_write_en_o === 1'b1) wr_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete request. rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  // hold keeps req_valid_i asserted for the whole transfer.
  task automatic run_txn(input logic rel, input logic [4:0] idx, input logic [2:0] way,
                         input logic [2:0] prm, input logic [1:0] nst,
                         input logic [3:0] src, input int rmode, input logic hold);
    bit          dirty;
    int          nb, sent, k;
    logic [2:0]  exp_op;
    logic [63:0] exp_addr, exp_data;
    logic        rdy;

    check("idle_ready", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_is_release_i = rel;
    req_index_i = idx;
    req_way_i = way;
    req_param_i = prm;
    req_new_state_i = nst;
    req_source_i = src;
    @(posedge clk_i); #1;
    if (!hold) req_valid_i = 1'b0;

    // Lookup cycle
    check("lookup_busy", 64'(busy_o), 64'd1);
    check("lookup_ready", 64'(req_ready_o), 64'd0);
    check("lookup_cvalid", 64'(c_valid_o), 64'd0);

    dirty = (sts[idx][way] == 2'd3);
    nb = dirty ? 8 : 1;
    exp_op = 3'(4 + (rel ? 2 : 0) + (dirty ? 1 : 0));
    exp_addr = {tags[idx][way], idx, 6'd0};

    sent = 0;
    k = 0;
    while (sent < nb && k < BUDGET) begin
      @(posedge clk_i); #1;
      exp_data = dirty ? mem[idx][way][sent] : 64'd0;
      check("beat_valid", 64'(c_valid_o), 64'd1);
      check("beat_opcode", 64'(c_opcode_o), 64'(exp_op));
      check("beat_data", c_data_o, exp_data);
      check("beat_addr", c_address_o, exp_addr);
      check("beat_param", 64'(c_param_o), 64'(prm));
      check("beat_source", 64'(c_source_o), 64'(src));
      check("beat_size", 64'(c_size_o), 64'd6);
      check("beat_ready_low", 64'(req_ready_o), 64'd0);
      check("beat_no_write", 64'(arr_write_en_o), 64'd0);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      c_ready_i = rdy;
      if (rdy) sent++;
      k++;
    end
    check("beats_within_budget", 64'(sent), 64'(nb));

    // Update cycle
    @(posedge clk_i); #1;
    c_ready_i = 1'b0;
    check("upd_done", 64'(done_o), 64'd1);
    check("upd_wen", 64'(arr_write_en_o), 64'd1);
    check("upd_be", 64'(arr_be_o), 64'd0);
    check("upd_tag", 64'(arr_tag_o), 64'(tags[idx][way]));
    check("upd_state", 64'(arr_state_o), 64'(nst));
    check("upd_index", 64'(arr_index_o), 64'(idx));
    check("upd_way", 64'(arr_way_sel_o), 64'(way));
    check("upd_cvalid", 64'(c_valid_o), 64'd0);
    check("upd_ready_low", 64'(req_ready_o), 64'd0);
    sts[idx][way] = nst;

    @(posedge clk_i); #1;
    check("back_ready", 64'(req_ready_o), 64'd1);
    check("back_busy", 64'(busy_o), 64'd0);
    check("back_done", 64'(done_o), 64'd0);
  endtask

  initial begin
    int w0;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_is_release_i = 1'b0;
    req_index_i = '0;
    req_way_i = '0;
    req_param_i = '0;
    req_new_state_i = '0;
    req_source_i = '0;
    c_ready_i = 1'b0;
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 8; w++) begin
        tags[s][w] = TAG_W'({$urandom, $urandom});
        sts[s][w] = 2'($urandom_range(0, 3));
        for (int d = 0; d < 8; d++) mem[s][w][d] = {$urandom, $urandom};
      end

    // Reset values
    #12;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_index", 64'(arr_index_o), 64'd0);
    check("rst_word", 64'(arr_word_sel_o), 64'd0);
    check("rst_way", 64'(arr_way_sel_o), 64'd0);
    check("rst_wen", 64'(arr_write_en_o), 64'd0);
    check("rst_be", 64'(arr_be_o), 64'd0);
    check("rst_atag", 64'(arr_tag_o), 64'd0);
    check("rst_astate", 64'(arr_state_o), 64'd0);
    check("rst_cvalid", 64'(c_valid_o), 64'd0);
    check("rst_opcode", 64'(c_opcode_o), 64'd0);
    check("rst_param", 64'(c_param_o), 64'd0);
    check("rst_size", 64'(c_size_o), 64'd6);
    check("rst_source", 64'(c_source_o), 64'd0);
    check("rst_addr", c_address_o, 64'd0);
    check("rst_data", c_data_o, 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Dirty release of way 3, set 5: eight data beats, state goes to N.
    for (int k = 0; k < 8; k++) mem[5][3][k] = 64'h1000 + 64'(k);
    sts[5][3] = 2'd3;
    run_txn(1'b1, 5'd5, 3'd3, 3'd1, 2'd0, 4'h9, 0, 1'b0);

    // Clean probe ack from MESI_B: one dataless beat.
    sts[7][2] = 2'd1;
    run_txn(1'b0, 5'd7, 3'd2, 3'd4, 2'd1, 4'h3, 0, 1'b0);

    // Dirty line under 1,0,0,1 backpressure.
    sts[9][6] = 2'd3;
    run_txn(1'b1, 5'd9, 3'd6, 3'd2, 2'd0, 4'h5, 1, 1'b0);

    // Request held during a transfer; the follow-on is taken after done_o.
    sts[10][1] = 2'd3;
    sts[11][4] = 2'd2;
    run_txn(1'b0, 5'd10, 3'd1, 3'd3, 2'd1, 4'h7, 0, 1'b1);
    run_txn(1'b1, 5'd11, 3'd4, 3'd0, 2'd0, 4'h2, 0, 1'b0);

    // Release of an invalid line: dataless, state still written.
    sts[12][0] = 2'd0;
    run_txn(1'b1, 5'd12, 3'd0, 3'd5, 2'd0, 4'hc, 0, 1'b0);

    // Reset after the fourth beat is on the wire: no array write may follow.
    sts[14][4] = 2'd3;
    w0 = wr_count;
    req_valid_i = 1'b1;
    req_is_release_i = 1'b1;
    req_index_i = 5'd14;
    req_way_i = 3'd4;
    req_new_state_i = 2'd0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    c_ready_i = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    check("mid_beat_data", c_data_o, mem[14][4][3]);
    rst_ni = 1'b0;
    #1;
    check("midrst_cvalid", 64'(c_valid_o), 64'd0);
    check("midrst_ready", 64'(req_ready_o), 64'd1);
    check("midrst_wen", 64'(arr_write_en_o), 64'd0);
    check("midrst_data", c_data_o, 64'd0);
    c_ready_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (4) begin @(posedge clk_i); #1; end
    check("midrst_no_write", 64'(wr_count), 64'(w0));
    check("midrst_idle", 64'(busy_o), 64'd0);

    // Randomized requests with random backpressure.
    for (int t = 0; t < 16; t++) begin
      run_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
